// File: rtl/lfsr_32bits_pkg.sv
// rtl/lfsr_32bits_pkg.sv - shared LFSR taps, next-state function and checker FSM state type
package lfsr_32bits_pkg;

    localparam int          LFSR_W   = 32;
    // Feedback taps at bits 31, 21, 1 and 0
    localparam logic [31:0] TAP_MASK = 32'h8020_0003;

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_SYNC,
        ST_LOCKED
    } state_t;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
        return {q[LFSR_W-2:0], ^(q & TAP_MASK)};
    endfunction

endpackage

// File: rtl/lfsr_32bits_checker_popcount32.sv
// rtl/lfsr_32bits_checker_popcount32.sv - combinational 32-bit population count
module popcount32 (
    input  logic [31:0] data_i,
    output logic [5:0]  count_o
);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < 32; i++) begin
            count_o = count_o + 6'(data_i[i]);
        end
    end

endmodule

// File: rtl/lfsr_32bits_checker.sv
// rtl/lfsr_32bits_checker.sv - 32-bit LFSR sequence checker with hunt/sync/lock acquisition
module lfsr_32bits_checker
    import lfsr_32bits_pkg::*;
#(
    parameter int SYNC_CNT = 4,
    parameter int LOSS_CNT = 4
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [31:0] din,
    input  logic        din_valid,
    input  logic        clr_cnt,
    output logic        locked,
    output logic        err,
    output logic [5:0]  err_bits,
    output logic [15:0] err_cnt
);

    state_t      state_q, state_d;
    logic [31:0] ref_q, ref_d;
    logic [3:0]  good_q, good_d;
    logic [3:0]  bad_q, bad_d;
    logic        locked_q;
    logic        err_q, err_d;
    logic [5:0]  bits_q, bits_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] pred;
    logic [5:0]  diff_bits;

    assign pred = lfsr_next(ref_q);

    popcount32 u_popcount (
        .data_i  (din ^ pred),
        .count_o (diff_bits)
    );

    always_comb begin
        state_d = state_q;
        ref_d   = ref_q;
        good_d  = good_q;
        bad_d   = bad_q;
        err_d   = 1'b0;
        bits_d  = bits_q;
        cnt_d   = cnt_q;
        if (din_valid) begin
            case (state_q)
                ST_HUNT: begin
                    // All-zero is the lockup word and can never seed the reference
                    if (din != '0) begin
                        ref_d   = din;
                        good_d  = '0;
                        state_d = ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    ref_d = din;
                    if (din == pred) begin
                        good_d = good_q + 4'd1;
                        if (good_d == 4'(SYNC_CNT)) begin
                            state_d = ST_LOCKED;
                            bad_d   = '0;
                        end
                    end else if (din == '0) begin
                        state_d = ST_HUNT;
                    end else begin
                        good_d = '0;
                    end
                end
                ST_LOCKED: begin
                    // Reference free-runs once locked; received data never reseeds it
                    ref_d = pred;
                    if (din == pred) begin
                        bad_d  = '0;
                        bits_d = '0;
                    end else begin
                        err_d  = 1'b1;
                        bits_d = diff_bits;
                        cnt_d  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                        bad_d  = bad_q + 4'd1;
                        if (bad_d == 4'(LOSS_CNT)) begin
                            state_d = ST_HUNT;
                        end
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end
        if (clr_cnt) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q  <= ST_HUNT;
            ref_q    <= '0;
            good_q   <= '0;
            bad_q    <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            bits_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ref_q    <= ref_d;
            good_q   <= good_d;
            bad_q    <= bad_d;
            locked_q <= (state_d == ST_LOCKED);
            err_q    <= err_d;
            bits_q   <= bits_d;
            cnt_q    <= cnt_d;
        end
    end

    assign locked   = locked_q;
    assign err      = err_q;
    assign err_bits = bits_q;
    assign err_cnt  = cnt_q;

endmodule

// File: tb/tb_lfsr_32bits_checker.sv
// tb/tb_lfsr_32bits_checker.sv - self-checking bench for lfsr_32bits_checker
module tb_lfsr_32bits_checker;

    logic        clk = 1'b0;
    logic        rst       [2];
    logic [31:0] din       [2];
    logic        din_valid [2];
    logic        clr_cnt   [2];
    logic        locked    [2];
    logic        err       [2];
    logic [5:0]  err_bits  [2];
    logic [15:0] err_cnt   [2];

    int tests = 0;
    int fails = 0;

    int          m_mode   [2];
    logic [31:0] m_ref    [2];
    int          m_good   [2];
    int          m_bad    [2];
    int          m_locked [2];
    int          m_err    [2];
    int          m_bits   [2];
    int          m_cnt    [2];
    logic [31:0] r        [2];

    always #5 clk = ~clk;

    lfsr_32bits_checker #(.SYNC_CNT(4), .LOSS_CNT(4)) dut_a (
        .sys_clk   (clk),
        .sys_rst   (rst[0]),
        .din       (din[0]),
        .din_valid (din_valid[0]),
        .clr_cnt   (clr_cnt[0]),
        .locked    (locked[0]),
        .err       (err[0]),
        .err_bits  (err_bits[0]),
        .err_cnt   (err_cnt[0])
    );

    lfsr_32bits_checker #(.SYNC_CNT(4), .LOSS_CNT(15)) dut_b (
        .sys_clk   (clk),
        .sys_rst   (rst[1]),
        .din       (din[1]),
        .din_valid (din_valid[1]),
        .clr_cnt   (clr_cnt[1]),
        .locked    (locked[1]),
        .err       (err[1]),
        .err_bits  (err_bits[1]),
        .err_cnt   (err_cnt[1])
    );

    function automatic logic [31:0] nxt(input logic [31:0] q);
        logic fb;
        fb = q[31] ^ q[21] ^ q[1] ^ q[0];
        return (q << 1) | {31'd0, fb};
    endfunction

    task automatic check(input string name, input int k, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s inst%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 = hunting, 1 = syncing, 2 = locked
    task automatic model_step(input int k);
        int          lc;
        logic [31:0] p;
        lc = (k == 0) ? 4 : 15;
        if (rst[k]) begin
            m_mode[k] = 0; m_ref[k] = '0; m_good[k] = 0; m_bad[k] = 0;
            m_err[k] = 0; m_bits[k] = 0; m_cnt[k] = 0; m_locked[k] = 0;
            return;
        end
        m_err[k] = 0;
        if (din_valid[k]) begin
            if (m_mode[k] == 0) begin
                if (din[k] != 0) begin
                    m_ref[k] = din[k]; m_good[k] = 0; m_mode[k] = 1;
                end
            end else if (m_mode[k] == 1) begin
                if (din[k] == nxt(m_ref[k])) begin
                    m_good[k]++;
                    if (m_good[k] == 4) begin m_mode[k] = 2; m_bad[k] = 0; end
                end else if (din[k] == 0) begin
                    m_mode[k] = 0;
                end else begin
                    m_good[k] = 0;
                end
                m_ref[k] = din[k];
            end else begin
                p = nxt(m_ref[k]);
                m_ref[k] = p;
                if (din[k] == p) begin
                    m_bad[k] = 0; m_bits[k] = 0;
                end else begin
                    m_err[k] = 1;
                    m_bits[k] = $countones(din[k] ^ p);
                    if (m_cnt[k] < 65535) m_cnt[k]++;
                    m_bad[k]++;
                    if (m_bad[k] == lc) m_mode[k] = 0;
                end
            end
        end
        if (clr_cnt[k]) m_cnt[k] = 0;
        m_locked[k] = (m_mode[k] == 2) ? 1 : 0;
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) model_step(k);
        #1;
        for (int k = 0; k < 2; k++) begin
            check("model_locked",   k, locked[k],   m_locked[k]);
            check("model_err",      k, err[k],      m_err[k]);
            check("model_err_bits", k, err_bits[k], m_bits[k]);
            check("model_err_cnt",  k, err_cnt[k],  m_cnt[k]);
        end
    end

    task automatic cyc(input int k, input logic [31:0] d, input logic v, input logic c);
        @(negedge clk);
        din[k] = d; din_valid[k] = v; clr_cnt[k] = c;
        @(posedge clk);
        #2;
        din_valid[k] = 1'b0; clr_cnt[k] = 1'b0;
    endtask

    task automatic lock_seq(input int k);
        cyc(k, 32'h0000_0001, 1'b1, 1'b0);
        cyc(k, 32'h0000_0003, 1'b1, 1'b0);
        cyc(k, 32'h0000_0006, 1'b1, 1'b0);
        cyc(k, 32'h0000_000D, 1'b1, 1'b0);
        check("pre_lock", k, locked[k], 0);
        cyc(k, 32'h0000_001B, 1'b1, 1'b0);
        check("lock_after_1b", k, locked[k], 1);
        r[k] = 32'h0000_001B;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; din[k] = '0; din_valid[k] = 1'b0; clr_cnt[k] = 1'b0;
        end
        din_valid[0] = 1'b1; clr_cnt[0] = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check("rst_locked",   0, locked[0],   0);
        check("rst_err",      0, err[0],      0);
        check("rst_err_bits", 0, err_bits[0], 0);
        check("rst_err_cnt",  0, err_cnt[0],  16'h0000);
        @(negedge clk);
        din_valid[0] = 1'b0; clr_cnt[0] = 1'b0;
        rst[0] = 1'b0; rst[1] = 1'b0;

        // Acquire lock, single-bit error, recovery
        lock_seq(0);
        cyc(0, nxt(r[0]) ^ 32'h1, 1'b1, 1'b0);
        r[0] = nxt(r[0]);
        check("single_err",      0, err[0],      1);
        check("single_err_bits", 0, err_bits[0], 1);
        check("single_err_cnt",  0, err_cnt[0],  1);
        check("single_locked",   0, locked[0],   1);
        r[0] = nxt(r[0]);
        cyc(0, r[0], 1'b1, 1'b0);
        check("after_err_word", 0, din[0], 32'h0000_006D);
        check("after_err_clean", 0, err[0], 0);

        // Idle gap mid-lock
        repeat (5) cyc(0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        check("idle_locked", 0, locked[0], 1);
        repeat (3) begin
            r[0] = nxt(r[0]);
            cyc(0, r[0], 1'b1, 1'b0);
            check("resume_err", 0, err[0], 0);
        end
        check("resume_locked", 0, locked[0], 1);

        // Clear, then four inverted words lose lock
        cyc(0, '0, 1'b0, 1'b1);
        check("clr_idle", 0, err_cnt[0], 0);
        for (int i = 0; i < 4; i++) begin
            r[0] = nxt(r[0]);
            cyc(0, ~r[0], 1'b1, 1'b0);
            check("inv_err_bits", 0, err_bits[0], 32);
            check("inv_err",      0, err[0],      1);
        end
        check("loss_err_cnt", 0, err_cnt[0], 4);
        check("loss_locked",  0, locked[0],  0);
        repeat (3) begin
            cyc(0, 32'h0, 1'b1, 1'b0);
            check("zero_hunt", 0, locked[0], 0);
        end
        check("hunt_err_bits_held", 0, err_bits[0], 32);

        // Sync reseed and zero fallback, then relock and mid-lock reset
        cyc(0, 32'h5, 1'b1, 1'b0);
        cyc(0, 32'h7, 1'b1, 1'b0);
        cyc(0, 32'h0, 1'b1, 1'b0);
        check("sync_no_lock", 0, locked[0], 0);
        lock_seq(0);
        @(negedge clk);
        rst[0] = 1'b1; din_valid[0] = 1'b1; din[0] = nxt(r[0]); clr_cnt[0] = 1'b1;
        @(posedge clk); #2;
        check("midlock_rst_locked", 0, locked[0], 0);
        check("midlock_rst_cnt",    0, err_cnt[0], 0);
        rst[0] = 1'b0; din_valid[0] = 1'b0; clr_cnt[0] = 1'b0;
        r[0] = nxt(nxt(r[0]));
        cyc(0, r[0], 1'b1, 1'b0);
        check("post_rst_hunt", 0, locked[0], 0);
        check("post_rst_err",  0, err[0],    0);

        // Saturation on the LOSS_CNT=15 instance
        lock_seq(1);
        for (int g = 0; g < 4681; g++) begin
            for (int i = 0; i < 14; i++) begin
                r[1] = nxt(r[1]);
                cyc(1, r[1] ^ 32'h8000_0000, 1'b1, 1'b0);
            end
            r[1] = nxt(r[1]);
            cyc(1, r[1], 1'b1, 1'b0);
        end
        check("sat_still_locked", 1, locked[1], 1);
        r[1] = nxt(r[1]);
        cyc(1, r[1] ^ 32'h3, 1'b1, 1'b0);
        check("sat_reach", 1, err_cnt[1], 16'hFFFF);
        r[1] = nxt(r[1]);
        cyc(1, r[1] ^ 32'h1, 1'b1, 1'b0);
        check("sat_hold",     1, err_cnt[1], 16'hFFFF);
        check("sat_hold_err", 1, err[1],     1);
        r[1] = nxt(r[1]);
        cyc(1, r[1] ^ 32'h1, 1'b1, 1'b1);
        check("clr_prio_cnt", 1, err_cnt[1], 16'h0000);
        check("clr_prio_err", 1, err[1],     1);
        cyc(1, '0, 1'b0, 1'b0);
        check("idle_err_low", 1, err[1], 0);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lfsr_32bits_checker.md
LFSR_32BITS_CHECKER -- requirements
Module: lfsr_32bits_checker

Interface
REQ-001 SYNC_CNT, 4, consecutive correct predictions after seeding needed to declare lock (1..15).
REQ-002 LOSS_CNT, 4, consecutive mismatched words in lock that force loss of lock (1..15).
REQ-003 sys_clk  input  1  single clock, all logic on rising edge.
REQ-004 sys_rst  input  1  reset, synchronous, active-high.
REQ-005 din  input  32  received LFSR word, one LFSR step per valid word.
REQ-006 din_valid  input  1  din qualifier; low = idle cycle.
REQ-007 clr_cnt  input  1  synchronous clear of err_cnt.
REQ-008 locked  output  1  high while in LOCKED state.
REQ-009 err  output  1  one-cycle pulse: last valid word mismatched while locked.
REQ-010 err_bits  output  6  popcount of (din XOR prediction) for the last checked locked word, 0..32.
REQ-011 err_cnt  output  16  saturating count of mismatched words while locked.

Function
REQ-012 Sequence SHALL be the team's 32-bit Fibonacci LFSR: next(Q) = {Q[30:0], Q[31]^Q[21]^Q[1]^Q[0]}.
REQ-013 FSM states SHALL be HUNT, SYNC, LOCKED; held reference register ref[31:0]; counters good_cnt, bad_cnt.
REQ-014 HUNT: valid nonzero din -> ref<=din, good_cnt<=0, go SYNC; valid zero din -> stay HUNT (all-zero is the lockup word, never seeded).
REQ-015 SYNC: on valid, ref<=din; din==next(ref) -> good_cnt++; reaching SYNC_CNT -> LOCKED, bad_cnt<=0.
REQ-016 SYNC mismatch: nonzero din -> reseed, good_cnt<=0, stay SYNC; zero din -> HUNT.
REQ-017 LOCKED: on valid, ref<=next(ref) (free-running; din never reseeds), prediction=next(ref).
REQ-018 LOCKED match: bad_cnt<=0, err<=0, err_bits<=0.
REQ-019 LOCKED mismatch: err<=1 for one cycle, err_bits<=popcount, err_cnt saturating increment, bad_cnt++; reaching LOSS_CNT -> HUNT.
REQ-020 All outputs SHALL be registered; response appears the cycle after the valid din cycle (latency 1).
REQ-021 din_valid low: no state, ref, counter change; err SHALL be 0; err_bits holds.
REQ-022 err_cnt SHALL stay at 0xFFFF on further errors.
REQ-023 clr_cnt SHALL take priority over a simultaneous increment (err_cnt=0); err pulse still issued.
REQ-024 err, err_bits, err_cnt SHALL never change outside LOCKED except by reset/clr_cnt.
REQ-025 locked SHALL drop in the same cycle err reports the LOSS_CNT-th mismatch.

Reset
REQ-026 sys_rst high SHALL force state HUNT, ref=0, good_cnt=0, bad_cnt=0, locked=0, err=0, err_bits=0, err_cnt=0 on the next edge.
REQ-027 Reset SHALL override din_valid and clr_cnt; mid-lock reset discards lock, first valid word after release is treated as HUNT.

Structure
REQ-028 Shared package lfsr_32bits_pkg SHALL hold the tap constants, the next-state function and the FSM state type, shared with lfsr_32bits.
REQ-029 One sub-module popcount32 (32-bit in, 6-bit out, combinational) SHALL compute err_bits.

Verification
REQ-030 Reset asserted 2 cycles -> locked=0, err=0, err_bits=0, err_cnt=0x0000.
REQ-031 Words 0x00000001,0x00000003,0x00000006,0x0000000D,0x0000001B valid back-to-back -> locked=1 one cycle after 0x1B, err never 1.
REQ-032 Locked, expected 0x00000036 sent as 0x00000037, then 0x0000006D -> err one cycle, err_bits=1, err_cnt=1, locked stays 1, next word no error.
REQ-033 Locked, 4 consecutive words XOR 0xFFFFFFFF -> err_bits=32 each, err_cnt=4, locked=0 after 4th; subsequent 0x00000000 words keep HUNT.
REQ-034 err_cnt forced to 0xFFFF by 65535 errors (LOSS_CNT=15 with periodic good words), one more error -> 0xFFFF; clr_cnt with error same cycle -> 0x0000, err=1.
REQ-035 din_valid low for 5 cycles mid-lock then resume correct sequence -> no err, locked stays 1.
